// File: rtl/muxn_arb.sv
// N-channel valid/ready multiplexer into a single registered output word.
// Grant policy is either an explicit select (MODE 0) or cyclic round-robin (MODE 1).
module muxn_arb #(
  parameter  int unsigned BIT  = 4,
  parameter  int unsigned N    = 4,
  parameter  int unsigned MODE = 0,
  localparam int unsigned SW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*BIT-1:0]   in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SW-1:0]      sel,
  output logic [BIT-1:0]     out,
  output logic [SW-1:0]      out_ch,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [BIT-1:0] out_q, out_d;
  logic [SW-1:0]  out_ch_q, out_ch_d;
  logic           out_valid_q, out_valid_d;
  logic [SW-1:0]  ptr_q, ptr_d;

  logic           can_accept;
  logic           grant_any;
  logic [SW-1:0]  grant_idx;
  logic           xfer;
  logic [BIT-1:0] grant_word;

  // out_ready only matters while a word is held, so an empty stage never waits on it
  assign can_accept = !out_valid_q || out_ready;

  // Candidate channel, independent of whether the output stage can take it
  always_comb begin
    int unsigned cand;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    if (MODE == 0) begin
      if (32'(sel) < N) begin
        grant_any = in_valid[sel];
        grant_idx = sel;
      end
    end else begin
      for (int unsigned j = 0; j < N; j++) begin
        cand = 32'(ptr_q) + j;
        if (cand >= N) cand = cand - N;
        if (!grant_any && in_valid[SW'(cand)]) begin
          grant_any = 1'b1;
          grant_idx = SW'(cand);
        end
      end
    end
  end

  assign xfer       = grant_any && can_accept && !rst;
  assign in_ready   = xfer ? (N'(1) << grant_idx) : '0;
  assign grant_word = BIT'(in_data >> (32'(grant_idx) * BIT));

  // Next-state for the output register and the round-robin pointer
  always_comb begin
    out_d       = out_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_d       = grant_word;
      out_ch_d    = grant_idx;
      out_valid_d = 1'b1;
      if (MODE == 1) begin
        ptr_d = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out       = out_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

  a_ready_onehot : assert property (@(posedge clk) $onehot0(in_ready));
  a_ready_gated  : assert property (@(posedge clk) (in_ready != '0) |-> (can_accept && !rst));
  a_stall_hold   : assert property (@(posedge clk) disable iff (rst)
                     (out_valid_q && !out_ready) |=> ($stable(out_q) && $stable(out_ch_q) && out_valid_q));

endmodule
